// File: rtl/fifo_skew_reader.sv
// -----------------------------------------------------------------------------
// fifo_skew_reader
//
// Read-side controller for a bank of input FIFOs feeding the systolic array.
// On i_start it drains BurstLen words from each of NumLanes FIFOs. Lane i's
// first read is delayed by i cycles, which produces the diagonal skew the PE
// grid needs. If any active lane is empty, every lane stalls, so the skew
// alignment between lanes is never lost.
//
// State sequence: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
//
// Optional feature (compile-time macro): FIFO_SKEW_READER_STALL_CNT_EN
//   defined   : 16-bit saturating stall counter. It clears when RUN is
//               entered and holds its value through IDLE.
//   undefined : no counter is built and o_stall_count is tied to 0.
//
// Parameters:
//   NumLanes      number of FIFOs / array-edge lanes
//   DataSize      word width
//   BurstLen      words read per lane per pass (>= 1)
//
// Ports:
//   i_clk         clock; all logic runs on the rising edge
//   i_reset       synchronous, active-high reset
//   i_start       begins a pass; sampled only in IDLE
//   i_lane_empty  FIFO empty flags, bit i = lane i
//   i_lane_data   FIFO dataOut buses, lane i at [i*DataSize +: DataSize]
//   o_lane_r_en   read enables to the FIFOs
//   o_out_data    data to the array edge; lane forced to 0 when not valid
//   o_out_valid   per-lane valid for o_out_data (o_lane_r_en delayed 1 cycle)
//   o_busy        high in RUN and FLUSH
//   o_done        one-cycle pulse in DONE
//   o_stall_count stall cycles in the current or last pass
// -----------------------------------------------------------------------------
module fifo_skew_reader #(
    parameter int unsigned NumLanes = 4,
    parameter int unsigned DataSize = 8,
    parameter int unsigned BurstLen = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [NumLanes-1:0]          i_lane_empty,
    input  logic [NumLanes*DataSize-1:0] i_lane_data,
    output logic [NumLanes-1:0]          o_lane_r_en,
    output logic [NumLanes*DataSize-1:0] o_out_data,
    output logic [NumLanes-1:0]          o_out_valid,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [15:0]                  o_stall_count
);

    // Tick spans 0 .. BurstLen+NumLanes-2; the last lane's final read
    // happens at the top value.
    localparam int unsigned TickSpan = BurstLen + NumLanes;
    localparam int unsigned TickW    = (TickSpan > 2) ? $clog2(TickSpan) : 1;
    localparam int unsigned TickTop  = TickSpan - 2;
    localparam logic [TickW-1:0] TickLast = TickW'(TickTop);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [TickW-1:0]    r_tick;
    logic [TickW-1:0]    w_tick_next;
    logic [31:0]         w_tick_u;
    logic [NumLanes-1:0] w_active;
    logic                w_stall;
    logic [NumLanes-1:0] w_r_en;
    logic [NumLanes-1:0] r_out_valid;

    // Lane i is inside its read window when i <= tick < i + BurstLen.
    always_comb begin
        w_tick_u = 32'(r_tick);
        w_active = '0;
        for (int unsigned i = 0; i < NumLanes; i++) begin
            w_active[i] = (w_tick_u >= i) && (w_tick_u < i + BurstLen);
        end
    end

    // One empty active lane freezes every lane so the diagonal stays intact.
    assign w_stall = |(w_active & i_lane_empty);

    always_comb begin
        w_r_en = '0;
        if (r_state == StRun && !w_stall) begin
            w_r_en = w_active;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StRun;
                    w_tick_next  = '0;
                end
            end
            StRun: begin
                if (!w_stall) begin
                    if (r_tick == TickLast) begin
                        w_state_next = StFlush;
                    end else begin
                        w_tick_next = r_tick + 1'b1;
                    end
                end
            end
            // One cycle for the last read's data to come back from the FIFO.
            StFlush: w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_tick      <= '0;
            r_out_valid <= '0;
        end else begin
            r_state     <= w_state_next;
            r_tick      <= w_tick_next;
            r_out_valid <= w_r_en;
        end
    end

    // FIFO dataOut is registered, so data read in cycle N is present on
    // i_lane_data in cycle N+1, which lines up with r_out_valid.
    always_comb begin
        o_out_data = '0;
        for (int unsigned i = 0; i < NumLanes; i++) begin
            if (r_out_valid[i]) begin
                o_out_data[i*DataSize +: DataSize] = i_lane_data[i*DataSize +: DataSize];
            end
        end
    end

`ifdef FIFO_SKEW_READER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (r_state == StIdle && i_start) begin
            r_stall_cnt <= '0;
        end else if (r_state == StRun && w_stall && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_count = r_stall_cnt;
`else
    assign o_stall_count = '0;
`endif

    assign o_lane_r_en = w_r_en;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state == StRun) || (r_state == StFlush);
    assign o_done      = (r_state == StDone);

    // A read must never be issued to an empty FIFO.
    a_no_empty_read: assert property (@(posedge i_clk) disable iff (i_reset)
        (o_lane_r_en & i_lane_empty) == '0);

endmodule

// File: tb/tb_fifo_skew_reader.sv
module tb_fifo_skew_reader;

    localparam int NL = 4;
    localparam int DS = 8;
    localparam int BL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (burst_len = 4)
    logic          i_reset;
    logic          i_start;
    logic [NL-1:0] lane_empty;
    logic [NL*DS-1:0] lane_data;
    logic [NL-1:0] r_en;
    logic [NL*DS-1:0] out_data;
    logic [NL-1:0] out_valid;
    logic          busy;
    logic          done;
    logic [15:0]   sc;

    // Second DUT (burst_len = 1)
    logic          start1;
    logic [NL-1:0] lane_empty1;
    logic [NL*DS-1:0] lane_data1;
    logic [NL-1:0] r_en1;
    logic [NL*DS-1:0] out_data1;
    logic [NL-1:0] out_valid1;
    logic          busy1;
    logic          done1;
    logic [15:0]   sc1;

    fifo_skew_reader #(.NumLanes(NL), .DataSize(DS), .BurstLen(BL)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_lane_empty  (lane_empty),
        .i_lane_data   (lane_data),
        .o_lane_r_en   (r_en),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .o_busy        (busy),
        .o_done        (done),
        .o_stall_count (sc)
    );

    fifo_skew_reader #(.NumLanes(NL), .DataSize(DS), .BurstLen(1)) dut1 (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_start       (start1),
        .i_lane_empty  (lane_empty1),
        .i_lane_data   (lane_data1),
        .o_lane_r_en   (r_en1),
        .o_out_data    (out_data1),
        .o_out_valid   (out_valid1),
        .o_busy        (busy1),
        .o_done        (done1),
        .o_stall_count (sc1)
    );

    int total = 0;
    int bad   = 0;

    // FIFO emulation: preloaded queues, registered dataOut.
    logic [7:0] fq [NL][$];
    logic [7:0] dreg [NL];
    logic [NL-1:0] force_e;

    // Reference model: pass progress expressed as a count of completed
    // read steps plus a post-read countdown (2 = flush, 1 = done).
    bit         m_run;
    int         m_k;
    int         m_post;
    int         m_sc;
    logic [NL-1:0] m_valid;
    logic [7:0] m_word [NL];
    int         rd_cnt [NL];
    logic [NL-1:0] exp_r_en;
    bit         exp_stall;

    // Captured DUT values for literal checks.
    logic [NL-1:0] cap_ren, cap_vld, cap_ren1;
    logic       cap_dn, cap_dn1;

    function automatic logic [7:0] word_val(input int lane, input int idx);
        return 8'(16 + lane * 64 + idx);
    endfunction

    function automatic logic [NL-1:0] pattern(input int k);
        logic [NL-1:0] p;
        p = '0;
        for (int i = 0; i < NL; i++) p[i] = (k >= i) && (k < i + BL);
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NL*DS-1:0] ed;
        logic [15:0] esc;
        ed = '0;
        for (int i = 0; i < NL; i++) if (m_valid[i]) ed[i*DS +: DS] = m_word[i];
`ifdef FIFO_SKEW_READER_STALL_CNT_EN
        esc = 16'(m_sc);
`else
        esc = 16'd0;
`endif
        chk("m_r_en", 64'(r_en), 64'(exp_r_en));
        chk("m_out_valid", 64'(out_valid), 64'(m_valid));
        chk("m_out_data", 64'(out_data), 64'(ed));
        chk("m_busy", 64'(busy), 64'(m_run || m_post == 2));
        chk("m_done", 64'(done), 64'(m_post == 1));
        chk("m_stall_count", 64'(sc), 64'(esc));
    endtask

    // One clock cycle: drive inputs, compare mid-cycle, advance at the edge.
    task automatic cyc(input logic st, input logic rs, input logic [NL-1:0] fe, input logic st1);
        i_start = st;
        i_reset = rs;
        force_e = fe;
        start1  = st1;
        for (int i = 0; i < NL; i++) begin
            lane_empty[i] = fe[i] || (fq[i].size() == 0);
            lane_data[i*DS +: DS] = dreg[i];
        end
        exp_stall = 1'b0;
        exp_r_en  = '0;
        if (m_run) begin
            exp_stall = |(pattern(m_k) & lane_empty);
            exp_r_en  = exp_stall ? '0 : pattern(m_k);
        end
        #3;
        check_all();
        cap_ren  = r_en;
        cap_vld  = out_valid;
        cap_dn   = done;
        cap_ren1 = r_en1;
        cap_dn1  = done1;
        @(posedge clk);
        for (int i = 0; i < NL; i++) begin
            if (cap_ren[i] && fq[i].size() > 0) dreg[i] = fq[i].pop_front();
            if (exp_r_en[i]) begin
                m_word[i] = word_val(i, rd_cnt[i]);
                rd_cnt[i]++;
            end
        end
        m_valid = rs ? '0 : exp_r_en;
        if (rs) begin
            m_run = 0; m_post = 0; m_k = 0; m_sc = 0;
        end else if (!m_run && m_post == 0) begin
            if (st) begin m_run = 1; m_k = 0; m_sc = 0; end
        end else if (m_run) begin
            if (exp_stall) begin
                if (m_sc < 65535) m_sc++;
            end else begin
                m_k++;
                if (m_k == BL + NL - 1) begin m_run = 0; m_post = 2; end
            end
        end else begin
            m_post--;
        end
        #1;
    endtask

    logic [NL-1:0] t_full  [7]  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [NL-1:0] t_stall [10] = '{4'h1, 4'h3, 4'h7, 4'h0, 4'h0, 4'h0,
                                    4'hF, 4'hE, 4'hC, 4'h8};
    logic [NL-1:0] t_diag  [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    logic [15:0] exp_sc_lit;

    initial begin
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < 40; j++) fq[i].push_back(word_val(i, j));
            dreg[i] = 8'h00;
            rd_cnt[i] = 0;
            m_word[i] = 8'h00;
        end
        m_run = 0; m_k = 0; m_post = 0; m_sc = 0; m_valid = '0;
        i_reset = 1'b1; i_start = 1'b0; start1 = 1'b0; force_e = '0;
        lane_empty = '0; lane_data = '0;
        lane_empty1 = '0; lane_data1 = 32'hA5A5A5A5;

        @(posedge clk);
        #4;
        chk("reset_outputs", {6'd0, r_en, out_valid, busy, done, sc, out_data}, 64'd0);
        @(posedge clk);
        #1;
        cyc(0, 1, '0, 0);

        // Full pass, no stalls.
        cyc(1, 0, '0, 0);
        for (int c = 0; c < 9; c++) begin
            cyc(0, 0, '0, 0);
            chk("t1_r_en", 64'(cap_ren), (c < 7) ? 64'(t_full[c]) : 64'd0);
            chk("t1_valid", 64'(cap_vld), (c >= 1 && c < 8) ? 64'(t_full[c-1]) : 64'd0);
            chk("t1_done", 64'(cap_dn), 64'(c == 8));
        end

        // Back-to-back start in the IDLE cycle; lane 2 empty for 3 cycles at tick 3.
        cyc(1, 0, '0, 0);
        for (int c = 0; c < 12; c++) begin
            cyc(0, 0, (c >= 3 && c < 6) ? 4'b0100 : 4'b0000, 0);
            chk("t2_r_en", 64'(cap_ren), (c < 10) ? 64'(t_stall[c]) : 64'd0);
            chk("t2_done", 64'(cap_dn), 64'(c == 11));
        end
        cyc(0, 0, '0, 0);
`ifdef FIFO_SKEW_READER_STALL_CNT_EN
        exp_sc_lit = 16'd3;
`else
        exp_sc_lit = 16'd0;
`endif
        chk("t2_stall_count", 64'(sc), 64'(exp_sc_lit));

        // start held high through RUN, FLUSH and DONE: no second pass.
        cyc(1, 0, '0, 0);
        for (int c = 0; c < 10; c++) begin
            cyc((c < 9) ? 1'b1 : 1'b0, 0, '0, 0);
            chk("t3_r_en", 64'(cap_ren), (c < 7) ? 64'(t_full[c]) : 64'd0);
            chk("t3_done", 64'(cap_dn), 64'(c == 8));
        end
        chk("t3_idle_busy", 64'(busy), 64'd0);

        // Reset at tick 2, then a fresh pass from the current FIFO heads.
        cyc(1, 0, '0, 0);
        cyc(0, 0, '0, 0);
        cyc(0, 0, '0, 0);
        cyc(0, 1, '0, 0);
        chk("t4_after_reset", {6'd0, r_en, out_valid, busy, done, sc, out_data}, 64'd0);
        cyc(0, 0, '0, 0);
        cyc(1, 0, '0, 0);
        for (int c = 0; c < 9; c++) begin
            cyc(0, 0, '0, 0);
            chk("t4_r_en", 64'(cap_ren), (c < 7) ? 64'(t_full[c]) : 64'd0);
        end
        // Lane 0: 4+4+4 full passes + 3 partial reads + 4 = 19 words read.
        chk("t4_lane0_head", 64'(dreg[0]), 64'(8'h10 + 8'd18));

        // burst_len = 1: pure diagonal.
        cyc(0, 0, '0, 1);
        for (int c = 0; c < 6; c++) begin
            cyc(0, 0, '0, 0);
            chk("t5_r_en", 64'(cap_ren1), 64'(t_diag[c]));
            chk("t5_done", 64'(cap_dn1), 64'(c == 5));
        end
        cyc(0, 0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_skew_reader.md
# fifo_skew_reader

Read-side controller for a bank of input FIFOs feeding the systolic array. On `start` it drains `burst_len` words from each of `num_lanes` FIFOs, with lane i's first read delayed by i cycles to produce the diagonal skew the PE grid requires. It sits between the per-row/per-column `fifo` instances and the array edge. It issues `r_en` and presents returned data with per-lane valids. A single empty lane stalls every lane, so skew alignment is never lost.

## Interface
- `num_lanes`, 4: number of FIFOs/array edge lanes
- `data_size`, 8: word width
- `burst_len`, 16: words read per lane per pass (≥1)
- `clk` in 1: single clock, all logic on posedge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a pass; sampled only in IDLE
- `lane_empty` in `num_lanes`: FIFO `empty` flags, bit i = lane i
- `lane_data` in `num_lanes*data_size`: FIFO `dataOut` buses, lane i at `[i*data_size +: data_size]`
- `lane_r_en` out `num_lanes`: read enables to FIFOs
- `out_data` out `num_lanes*data_size`: data to array edge
- `out_valid` out `num_lanes`: per-lane valid for `out_data`
- `busy` out 1: high in RUN and FLUSH
- `done` out 1: one-cycle pulse at pass end
- `stall_count` out 16: stall cycles in current/last pass (see Configuration)

## Operation
- States: IDLE → RUN → FLUSH → DONE → IDLE.
- IDLE: `start`=1 → RUN; `tick` cleared to 0. `start` is ignored in any other state.
- Tick counter `tick`, width `$clog2(burst_len+num_lanes)`, spans 0 .. `burst_len+num_lanes-2`.
- Lane i is active when i ≤ `tick` < i+`burst_len`.
- `stall` = |(active & `lane_empty`), combinational.
- `lane_r_en[i]` = (state==RUN) & active[i] & ~`stall`. No read is issued while stalled.
- In RUN, when ~`stall`: `tick` increments.
  - At `tick`=`burst_len+num_lanes-2` with no stall → FLUSH.
- In RUN, when `stall`: `tick` holds and the stall counter increments, saturating at 0xFFFF.
- FLUSH lasts exactly 1 cycle, covering the final read's returned data, then → DONE.
- DONE lasts 1 cycle with `done`=1, then → IDLE.
- `out_valid[i]` = `lane_r_en[i]` registered by one cycle.
- `out_data` lane i = `lane_data` lane i when `out_valid[i]`, else 0. This is combinational, because FIFO `dataOut` is registered.
- Each lane receives exactly `burst_len` valids per pass, in FIFO order. Adjacent lanes are offset by exactly 1 cycle regardless of stalls.
- Reset at any state → IDLE, `tick`=0, stall counter=0. Partially read FIFO contents are not restored.

## Timing
- Reset values: `lane_r_en`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `stall_count`=0.
- `start` sampled at edge E0 → RUN from E0. `lane_r_en[0]` is high in cycle E0–E1 if lane 0 is non-empty.
- `out_valid[0]` is high in the cycle after its `r_en`.
- No-stall pass length: `burst_len+num_lanes-1` RUN cycles + 1 FLUSH + 1 DONE.
- Stalls add 1 cycle each to RUN. `out_valid` is 0 on all lanes in the cycle after a stall.
- `lane_empty` is used combinationally in the same cycle, so there is no speculative read of an empty FIFO.
- `done` pulse is coincident with `busy`=0.
- A `start` during DONE is ignored. A `start` in the following IDLE cycle is accepted, so back-to-back passes have a minimum gap of 1 idle cycle.

## Configuration
- `FIFO_SKEW_READER_STALL_CNT_EN` defined:
  - Stall counter is implemented.
  - It clears on the RUN entry edge and holds its value through IDLE until the next `start`.
  - `stall_count` reflects it.
- Not defined: no counter is implemented and `stall_count` is tied to 0.

## Test plan
- Lanes=4, burst_len=4, all FIFOs non-empty, `start` pulse:
  - `lane_r_en` = 0001, 0011, 0111, 1111, 1110, 1100, 1000 over 7 cycles.
  - `out_valid` is the same pattern one cycle later.
  - `done` pulses 2 cycles after the last read.
- Same setup, lane 2 empty for 3 cycles at `tick`=3:
  - All `r_en` are 0 for those 3 cycles, then the pattern resumes unchanged.
  - With the macro, `stall_count`=3.
- `start` asserted during RUN and during DONE: ignored, with no extra reads.
- `reset` at `tick`=2: next cycle all outputs 0 and state IDLE. A new `start` then reads from the current FIFO heads.
- burst_len=1, lanes=4: `lane_r_en` = 0001, 0010, 0100, 1000 (pure diagonal), `done` 2 cycles later.
- Data check with FIFOs preloaded 0x10.. per lane: each lane outputs its words in order and `out_data` is 0 whenever `out_valid`=0.
